// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes, FSM states
// and a width-generic two's-complement helper.
package muldiv_pkg;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

  // Helper works on a fixed wide vector; callers zero-extend and truncate,
  // which is exact for negation modulo 2^N. Supports WIDTH up to MAX_W.
  localparam int unsigned MAX_W = 64;
  localparam int unsigned NEG_W = 2 * MAX_W;

  function automatic logic [NEG_W-1:0] cond_neg(input logic [NEG_W-1:0] x, input logic en);
    return en ? (~x + NEG_W'(1)) : x;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring shift-subtract divide.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 div_i,
  input  logic [2*WIDTH-1:0]   acc_i,
  input  logic [WIDTH-1:0]     m_i,
  output logic [2*WIDTH-1:0]   acc_o
);

  logic [WIDTH:0] sum_c;
  logic [WIDTH:0] shl_c;
  logic [WIDTH:0] diff_c;

  // acc holds {product_hi, multiplier} for multiply, {remainder, dividend/quotient} for divide
  always_comb begin
    sum_c  = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, m_i} : {(WIDTH+1){1'b0}});
    shl_c  = acc_i[2*WIDTH-1:WIDTH-1];
    diff_c = shl_c - {1'b0, m_i};
    if (div_i) begin
      if (diff_c[WIDTH]) begin
        acc_o = {shl_c[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
      end else begin
        acc_o = {diff_c[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
      end
    end else begin
      acc_o = {sum_c, acc_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULTU/MULT/DIVU/DIV unit with architectural HI/LO registers and
// MTHI/MTLO writes; WIDTH+1 cycles from accepted start to done.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned AW = 2 * WIDTH;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic             sa_q, sa_d, sb_q, sb_d;
  logic [WIDTH-1:0] a_q, a_d, m_q, m_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic             busy_q, busy_d, done_q, done_d, dz_q, dz_d;

  logic [AW-1:0]    step_acc_c, prod_c;
  logic [WIDTH-1:0] abs_a_c, abs_b_c, quot_c, rem_c;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .div_i (op_q[1]),
    .acc_i (acc_q),
    .m_i   (m_q),
    .acc_o (step_acc_c)
  );

  // Operand magnitudes on entry and sign-corrected results on exit
  always_comb begin
    abs_a_c = WIDTH'(cond_neg(NEG_W'(a), op[0] & a[WIDTH-1]));
    abs_b_c = WIDTH'(cond_neg(NEG_W'(b), op[0] & b[WIDTH-1]));
    prod_c  = AW'(cond_neg(NEG_W'(acc_q), op_q[0] & (sa_q ^ sb_q)));
    quot_c  = WIDTH'(cond_neg(NEG_W'(acc_q[WIDTH-1:0]), op_q[0] & (sa_q ^ sb_q)));
    rem_c   = WIDTH'(cond_neg(NEG_W'(acc_q[AW-1:WIDTH]), op_q[0] & sa_q));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    a_d     = a_q;
    m_d     = m_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dz_d    = dz_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = op;
          sa_d    = a[WIDTH-1];
          sb_d    = b[WIDTH-1];
          a_d     = a;
          dz_d    = op[1] & (b == '0);
          cnt_d   = CW'(WIDTH - 1);
          busy_d  = 1'b1;
          state_d = RUN;
          if (op[1]) begin
            m_d   = abs_b_c;
            acc_d = {{WIDTH{1'b0}}, abs_a_c};
          end else begin
            m_d   = abs_a_c;
            acc_d = {{WIDTH{1'b0}}, abs_b_c};
          end
        end else begin
          if (hi_we) hi_d = wdata;
          if (lo_we) lo_d = wdata;
        end
      end
      RUN: begin
        acc_d = step_acc_c;
        if (cnt_q == '0) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      FIX: begin
        // Divide by zero reports all-ones quotient and the raw dividend
        if (dz_q) begin
          hi_d = a_q;
          lo_d = '1;
        end else if (op_q[1]) begin
          hi_d = rem_c;
          lo_d = quot_c;
        end else begin
          hi_d = prod_c[AW-1:WIDTH];
          lo_d = prod_c[WIDTH-1:0];
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      a_q     <= '0;
      m_q     <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      a_q     <= a_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign dz   = dz_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: arithmetic reference model compared every
// cycle, plus directed vectors with hand-computed results.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         hi_we = 1'b0;
  logic         lo_we = 1'b0;
  logic [W-1:0] wdata = '0;
  logic         busy, done, dz;
  logic [W-1:0] hi, lo;

  int n_chk = 0;
  int n_fail = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .dz    (dz),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic: returns {hi, lo}
  function automatic logic [63:0] res_fn(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint      sx, sy;
    logic [63:0] r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'b00:   r = {32'b0, x} * {32'b0, y};
      2'b01:   r = 64'(sx * sy);
      2'b10:   r = (y == 0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
      default: r = (y == 0) ? {x, 32'hFFFF_FFFF} : {32'(sx % sy), 32'(sx / sy)};
    endcase
    return r;
  endfunction

  // Cycle-level behaviour model: fixed latency countdown, architectural HI/LO
  logic        m_busy, m_done, m_dz;
  logic [31:0] m_hi, m_lo;
  logic [63:0] pend;
  int          m_left;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_dz   <= 1'b0;
      m_hi   <= '0;
      m_lo   <= '0;
      m_left <= 0;
      pend   <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_left == 0) begin
        if (start) begin
          pend   <= res_fn(op, a, b);
          m_dz   <= op[1] && (b == 0);
          m_left <= W + 1;
          m_busy <= 1'b1;
        end else begin
          if (hi_we) m_hi <= wdata;
          if (lo_we) m_lo <= wdata;
        end
      end else begin
        if (m_left == 1) begin
          m_hi   <= pend[63:32];
          m_lo   <= pend[31:0];
          m_done <= 1'b1;
          m_busy <= 1'b0;
        end
        m_left <= m_left - 1;
      end
    end
  end

  always @(negedge clk) begin
    check("cmp_busy", W'(busy), W'(m_busy));
    check("cmp_done", W'(done), W'(m_done));
    check("cmp_dz", W'(dz), W'(m_dz));
    check("cmp_hi", hi, m_hi);
    check("cmp_lo", lo, m_lo);
    check("cmp_done_busy_excl", W'(done & busy), '0);
  end

  task automatic start_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
  endtask

  // Called at the negedge after the accepting edge; waits for done and checks literals
  task automatic finish_op(input string nm, input logic [W-1:0] eh, input logic [W-1:0] el,
                           input logic edz, input bit poke, input bit wrun);
    int n;
    n     = 0;
    start = 1'b0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    op    = 2'($urandom);
    a     = $urandom;
    b     = $urandom;
    check({nm, "_busy"}, W'(busy), W'(1));
    check({nm, "_dz_early"}, W'(dz), W'(edz));
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
      start = poke && (n == 5);
      hi_we = wrun && (n == 8);
      lo_we = wrun && (n == 8);
      wdata = 32'h0BAD_0BAD;
    end
    start = 1'b0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    check({nm, "_latency"}, W'(n), W'(W + 1));
    check({nm, "_done"}, W'(done), W'(1));
    check({nm, "_hi"}, hi, eh);
    check({nm, "_lo"}, lo, el);
    check({nm, "_dz"}, W'(dz), W'(edz));
  endtask

  initial begin
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_busy", W'(busy), '0);
    check("rst_done", W'(done), '0);
    check("rst_hi", hi, '0);
    check("rst_lo", lo, '0);
    reset = 1'b1;

    // MTHI / MTLO in IDLE
    @(negedge clk);
    hi_we = 1'b1; wdata = 32'h1234_5678;
    @(negedge clk);
    hi_we = 1'b0;
    check("mthi", hi, 32'h1234_5678);
    lo_we = 1'b1; wdata = 32'hCAFE_F00D;
    @(negedge clk);
    lo_we = 1'b0;
    check("mtlo", lo, 32'hCAFE_F00D);
    check("mtlo_hi_kept", hi, 32'h1234_5678);

    // MULTU with MTHI coinciding with start, start pokes and writes during RUN
    @(negedge clk);
    start_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("mthi_with_start", hi, 32'h1234_5678);
    finish_op("multu_max", 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b1, 1'b1);

    // MULT then back-to-back MULT in the done cycle
    @(negedge clk);
    start_op(OP_MULT, 32'hFFFF_FFFD, 32'd5);
    @(negedge clk);
    finish_op("mult_m3x5", 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 1'b0, 1'b0);
    start_op(OP_MULT, 32'd7, 32'hFFFF_FFF9);
    @(negedge clk);
    finish_op("mult_b2b", 32'hFFFF_FFFF, 32'hFFFF_FFCF, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    start_op(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    @(negedge clk);
    finish_op("div_m7d2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    start_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    @(negedge clk);
    finish_op("div_ovf", 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    start_op(OP_DIVU, 32'd100, 32'd0);
    @(negedge clk);
    finish_op("divu_dz", 32'h0000_0064, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("dz_hold", W'(dz), W'(1));

    @(negedge clk);
    start_op(OP_DIV, 32'hFFFF_FFFB, 32'd0);
    @(negedge clk);
    finish_op("div_dz_neg", 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);

    @(negedge clk);
    start_op(OP_DIV, 32'd7, 32'hFFFF_FFFE);
    @(negedge clk);
    finish_op("div_7dm2", 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    start_op(OP_MULT, 32'h8000_0000, 32'h8000_0000);
    @(negedge clk);
    finish_op("mult_minsq", 32'h4000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    start_op(OP_DIVU, 32'd100, 32'd7);
    @(negedge clk);
    finish_op("divu_100d7", 32'h0000_0002, 32'h0000_000E, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of RUN aborts the operation
    @(negedge clk);
    start_op(OP_MULTU, 32'h0000_1234, 32'h0000_5678);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("midrst_busy", W'(busy), '0);
    check("midrst_done", W'(done), '0);
    check("midrst_hi", hi, '0);
    check("midrst_lo", lo, '0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    start_op(OP_MULTU, 32'd3, 32'd4);
    @(negedge clk);
    finish_op("after_rst", 32'h0000_0000, 32'h0000_000C, 1'b0, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative multiply/divide unit with architectural HI/LO registers, replacing the single-cycle combinational multiplier and its load-enable HI/LO registers in the MIPS datapath. It executes MULTU, MULT, DIVU and DIV over WIDTH+1 cycles with a start/busy/done handshake. It also supports direct HI/LO writes (MTHI/MTLO). It sits beside the ALU: srca/srcb feed the operand inputs, and hi/lo feed the MFHI/MFLO result mux.

## Interface
- WIDTH, 32, operand and HI/LO width (≥4, even).
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin operation; sampled only in IDLE.
- op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- a  in  WIDTH  multiplicand / dividend.
- b  in  WIDTH  multiplier / divisor.
- hi_we  in  1  MTHI write strobe.
- lo_we  in  1  MTLO write strobe.
- wdata  in  WIDTH  MTHI/MTLO data.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; result valid on hi/lo.
- dz  out  1  last division had divisor 0.
- hi  out  WIDTH  HI register (product upper half / remainder).
- lo  out  WIDTH  LO register (product lower half / quotient).

## Operation
- States: IDLE, RUN, FIX.
- IDLE, start=1: latch op, a, b, and the magnitudes |a|, |b| (signed ops only). Clear dz; set dz=1 if the op is a divide and b==0. Load the iteration counter to WIDTH-1 and go to RUN.
- RUN: one radix-2 step per cycle on magnitudes.
  - Multiply: shift-add into a 2·WIDTH accumulator.
  - Divide: restoring shift-subtract with a WIDTH+1-bit partial remainder.
  - When the counter reaches 0, go to FIX; otherwise decrement.
- FIX: apply sign correction and write hi/lo, pulse done, return to IDLE.
  - MULT: negate the 2·WIDTH product if sign(a)≠sign(b).
  - DIV: negate the quotient if sign(a)≠sign(b); negate the remainder if a<0. This gives truncation toward zero, with the remainder taking the sign of the dividend.
- Divide by zero:
  - DIVU: lo = all ones, hi = a.
  - DIV: lo = all ones, hi = a.
  - dz=1 in both cases; the result is not an error and done pulses normally.
- DIV overflow (most negative ÷ -1): lo = most negative value, hi = 0 (two's-complement wrap).
- Unsigned ops perform no sign handling. Multiply and divide results are exact within WIDTH.
- hi_we/lo_we:
  - Honoured only in IDLE with start=0; the write lands at the next edge.
  - Ignored while busy, and ignored when start=1 in the same cycle.
- hi/lo hold their value except on a FIX write or an accepted hi_we/lo_we.

## Timing
- Reset (async assert, sync-safe deassert): state=IDLE, busy=0, done=0, dz=0, hi=0, lo=0, counter=0. Reset mid-operation aborts it with no result written.
- Start accepted at edge E0: busy=1 from E0.
- RUN occupies edges E1…EWIDTH; FIX is at edge EWIDTH+1.
- After EWIDTH+1:
  - hi/lo hold the new result.
  - done=1 for exactly one cycle.
  - busy=0.
- Latency from start to done: WIDTH+1 cycles (33 at WIDTH=32).
- Back-to-back: start may be asserted in the done cycle and is accepted at that edge.
- start while busy: ignored, with no queuing.
- a, b, op may change freely after E0.
- busy is registered; done is registered and is never high while busy=1.
- dz is valid from E0+1 and holds until the next accepted start.

## Structure
- Shared package muldiv_pkg:
  - op encoding constants OP_MULTU, OP_MULT, OP_DIVU, OP_DIV;
  - state enum {IDLE, RUN, FIX};
  - function for WIDTH-generic two's-complement negate/abs.
- The counter width is $clog2(WIDTH), declared locally.
- One sub-module is natural: muldiv_step, a combinational single-iteration datapath (add/shift or subtract/shift selected by op[1]). It is instantiated once, and the FSM and registers stay in muldiv_unit.
- The controller (aludec) gains a stall output driven by busy when MFHI/MFLO issue.

## Test plan
- Reset mid-RUN: assert reset low during cycle 10 → busy=0, hi=0, lo=0 immediately; a new start is accepted after release.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → done at E0+33, hi=0xFFFFFFFE, lo=0x00000001; start pulses while busy do not alter the result.
- MULT a=-3 (0xFFFFFFFD), b=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1. A back-to-back MULT 7×-7 started in the done cycle gives lo=0xFFFFFFCF, hi=0xFFFFFFFF.
- DIV a=-7, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV a=0x80000000, b=-1 → lo=0x80000000, hi=0, dz=0.
- DIVU a=100, b=0 → lo=0xFFFFFFFF, hi=0x00000064, dz=1.
- MTHI: hi_we=1, wdata=0x12345678 in IDLE → hi=0x12345678 next cycle. The same write during RUN is ignored, and so is a write coinciding with start.
